// File: rtl/rv32i_types.sv
// Shared types for the cacheline path: the rv32i word type, arbiter state
// encoding, and a modular-add helper used for pointer wrap.
package rv32i_types;

  typedef logic [31:0] rv32i_word;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  // (a + b) mod n, valid for a < n and b <= n; handles non-power-of-2 n
  function automatic int unsigned wrap_add(int unsigned a, int unsigned b, int unsigned n);
    int unsigned s;
    s = a + b;
    return (s >= n) ? (s - n) : s;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational requester picker: first requesting port at or after ptr,
// ascending with wrap. Fixed-priority builds scan from port 0.
module rr_picker
  import rv32i_types::*;
#(
  parameter int unsigned NUM_PORTS  = 2,
  parameter bit          FIXED_PRIO = 1'b0,
  localparam int unsigned IDX_W     = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_W-1:0]     ptr,
  output logic                 valid_c,
  output logic [IDX_W-1:0]     idx_c
);

  logic [IDX_W-1:0] start_c;

  assign start_c = FIXED_PRIO ? '0 : ptr;

  always_comb begin
    valid_c = 1'b0;
    idx_c   = '0;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      int unsigned cand;
      cand = wrap_add(32'(start_c), k, NUM_PORTS);
      if (!valid_c && req[IDX_W'(cand)]) begin
        valid_c = 1'b1;
        idx_c   = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/pmem_arbiter_rr.sv
// Multiplexes NUM_PORTS cacheline requesters onto the single pmem port.
// Grant is registered and held for the whole transaction.
module pmem_arbiter_rr
  import rv32i_types::*;
#(
  parameter int unsigned s_offset   = 4,
  parameter int unsigned size       = (2**s_offset)*8,
  parameter int unsigned NUM_PORTS  = 2,
  parameter bit          FIXED_PRIO = 1'b0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_PORTS-1:0][31:0]     req_address,
  input  logic [NUM_PORTS-1:0]           req_read,
  input  logic [NUM_PORTS-1:0]           req_write,
  input  logic [NUM_PORTS-1:0][size-1:0] req_wdata,
  output logic [NUM_PORTS-1:0][size-1:0] req_rdata,
  output logic [NUM_PORTS-1:0]           req_resp,
  input  logic [size-1:0]                pmem_rdata_c,
  input  logic                           pmem_resp_c,
  output logic [31:0]                    pmem_address_c,
  output logic                           pmem_read_c,
  output logic                           pmem_write_c,
  output logic [size-1:0]                pmem_wdata_c
);

  localparam int unsigned IDX_W = $clog2(NUM_PORTS);

  arb_state_t           state;
  logic [IDX_W-1:0]     owner;
  logic [IDX_W-1:0]     ptr;
  logic                 op_write;
  logic [NUM_PORTS-1:0] req_any_c;
  logic                 pick_valid_c;
  logic [IDX_W-1:0]     pick_idx_c;
  logic [IDX_W-1:0]     next_ptr_c;
  rv32i_word            owner_addr_c;

  assign req_any_c    = req_read | req_write;
  assign next_ptr_c   = IDX_W'(wrap_add(32'(owner), 32'd1, NUM_PORTS));
  assign owner_addr_c = req_address[owner];

  rr_picker #(
    .NUM_PORTS  (NUM_PORTS),
    .FIXED_PRIO (FIXED_PRIO)
  ) u_picker (
    .req     (req_any_c),
    .ptr     (ptr),
    .valid_c (pick_valid_c),
    .idx_c   (pick_idx_c)
  );

  // Grant/complete FSM; op is latched at grant so later bit changes are ignored
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ARB_IDLE;
      owner    <= '0;
      ptr      <= '0;
      op_write <= 1'b0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (pick_valid_c) begin
            owner    <= pick_idx_c;
            op_write <= req_write[pick_idx_c];
            state    <= ARB_BUSY;
          end
        end
        ARB_BUSY: begin
          if (pmem_resp_c) begin
            ptr   <= next_ptr_c;
            state <= ARB_IDLE;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  // Memory command and per-port response steering
  always_comb begin
    pmem_read_c    = 1'b0;
    pmem_write_c   = 1'b0;
    pmem_address_c = '0;
    pmem_wdata_c   = '0;
    req_rdata      = '0;
    req_resp       = '0;
    if (state == ARB_BUSY) begin
      pmem_read_c      = !op_write;
      pmem_write_c     = op_write;
      pmem_address_c   = owner_addr_c;
      pmem_wdata_c     = req_wdata[owner];
      req_rdata[owner] = pmem_rdata_c;
      req_resp[owner]  = pmem_resp_c;
    end
  end

endmodule
